// File: rtl/alu_apb_master.sv
// APB master that turns single command/response handshakes into APB transfers to the ALU slave.
// Latency: accept N, SETUP N+1, ACCESS N+2.., response valid the cycle after ACCESS exit; cmd_ready held low until the response is taken.
module alu_apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [31:0] prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t     state, next_state;
    logic [7:0] cnt;
    logic       ready_q;
    logic       accept;
    logic       timeout_hit;

    assign accept      = (state == IDLE) && cmd_valid && ready_q;
    assign timeout_hit = (cnt == 8'(TIMEOUT_CYCLES));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (pready || timeout_hit) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // cmd_ready is registered so it never depends on cmd_valid, and stays low until the first edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            cnt         <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            ready_q <= (next_state == IDLE);
            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end
            case (state)
                SETUP: cnt <= 8'd1;
                ACCESS: begin
                    // A late pready on the final allowed cycle still counts as a normal completion.
                    if (pready) begin
                        rsp_rdata   <= pwrite ? 32'd0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_rdata   <= 32'd0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign psel      = (state == SETUP) || (state == ACCESS);
    assign penable   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

endmodule
